// File: rtl/aes_dec_pkg.sv
// Shared definitions for the iterative AES-128 decryption core.
// Provides the FSM state type, the round count, GF(2^8) helpers (xtime, gmul,
// multiplicative inverse), forward/inverse S-box functions and the Rcon table.
package aes_dec_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {StIdle, StRound, StDone} dec_st_e;

  // Multiply by x modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] g;
    g = ginv(a);
    return g ^ rotl8(g, 1) ^ rotl8(g, 2) ^ rotl8(g, 3) ^ rotl8(g, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    unique case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decrypt_round.sv
// One combinational AES inverse round.
// Ports: state_in (128) current state, round_key (128) key to add,
// last_round (1) skips InvMixColumns, state_out (128) resulting state.
// Byte 0 is bits [127:120]; column c holds bytes 4c..4c+3.
module decrypt_round
  import aes_dec_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [7:0] b [16];
  logic [7:0] t [16];
  logic [7:0] coef [4];

  always_comb begin
    b         = '{default: 8'h00};
    t         = '{default: 8'h00};
    coef      = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    state_out = '0;
    for (int i = 0; i < 16; i++) begin
      b[i] = state_in[127 - 8*i -: 8];
    end
    // Row r rotates right by r: output column c takes input column c - r.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[4*c + r] = inv_sbox(b[4*((c - r + 4) % 4) + r]) ^ round_key[127 - 8*(4*c + r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (last_round) begin
          state_out[127 - 8*(4*c + r) -: 8] = t[4*c + r];
        end else begin
          state_out[127 - 8*(4*c + r) -: 8] = gmul(t[4*c + (r % 4)],       coef[0]) ^
                                              gmul(t[4*c + ((r + 1) % 4)], coef[1]) ^
                                              gmul(t[4*c + ((r + 2) % 4)], coef[2]) ^
                                              gmul(t[4*c + ((r + 3) % 4)], coef[3]);
        end
      end
    end
  end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryption: one inverse round per clock, ten rounds.
// Ports: clk, reset (async active-low); in_valid/in_ready handshake for
// dec_key_in (round-10 key) and dec_state_in (ciphertext); out_valid/out_ready
// handshake for dec_state_out (plaintext, held until the next completion).
// Round keys are produced by running the key schedule backwards from key_q.
module aes128_decrypt_iter
  import aes_dec_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] dec_key_in,
  input  logic [127:0] dec_state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dec_state_out
);

  function automatic logic [127:0] inv_key_exp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, tmp, sub;
    {w0, w1, w2, w3} = k;
    tmp = w3 ^ w2;
    tmp = {tmp[23:0], tmp[31:24]};
    sub = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
    return {w0 ^ sub ^ {rc, 24'h000000}, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  endfunction

  dec_st_e      state_q, state_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] key_q, key_d;
  logic [127:0] out_q, out_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         in_ready_q, in_ready_d;
  logic [127:0] kprev;
  logic [127:0] round_out;

  assign kprev = inv_key_exp(key_q, rcon(rnd_q));

  decrypt_round u_round (
    .state_in   (blk_q),
    .round_key  (kprev),
    .last_round (rnd_q == 4'd1),
    .state_out  (round_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      blk_q      <= '0;
      key_q      <= '0;
      out_q      <= '0;
      rnd_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      key_q      <= key_d;
      out_q      <= out_d;
      rnd_q      <= rnd_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    key_d   = key_q;
    out_d   = out_q;
    rnd_d   = rnd_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          blk_d   = dec_state_in ^ dec_key_in;
          key_d   = dec_key_in;
          rnd_d   = 4'(NR);
          state_d = StRound;
        end
      end
      StRound: begin
        blk_d = round_out;
        key_d = kprev;
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) begin
          out_d   = round_out;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Registered so in_ready stays low during reset and rises one cycle after release.
    in_ready_d = (state_d == StIdle);
  end

  always_comb begin
    in_ready      = in_ready_q;
    out_valid     = (state_q == StDone);
    dec_state_out = out_q;
  end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
module tb_aes128_decrypt_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] dec_key_in;
  logic [127:0] dec_state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dec_state_out;

  localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] exp_q [$];

  aes128_decrypt_iter dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .dec_key_in    (dec_key_in),
    .dec_state_in  (dec_state_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .dec_state_out (dec_state_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a block, waits for the accept edge and pushes the expected plaintext.
  task automatic accept(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt);
    int n;
    n = 0;
    dec_key_in   = k;
    dec_state_in = ct;
    in_valid     = 1'b1;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    exp_q.push_back(pt);
    step();
    in_valid = 1'b0;
  endtask

  // Returns the cycle (relative to the accept cycle T) at which out_valid is seen.
  task automatic wait_out(input int start, output int cyc);
    cyc = start;
    while (!out_valid && cyc < 60) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || dec_state_out !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%0b vld=%0b out=%h required 0/0/0",
               in_ready, out_valid, dec_state_out);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: rdy=%0b vld=%0b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic check_result(input int cyc, input string name);
    logic [127:0] e;
    vectors++;
    if (cyc != 11) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles required 11", name, cyc);
    end
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s_scoreboard: output with empty queue, got %h", name, dec_state_out);
    end else begin
      e = exp_q.pop_front();
      if (out_valid !== 1'b1 || dec_state_out !== e) begin
        miscompares++;
        $display("FAIL %s_data: vld=%0b got %h required %h", name, out_valid, dec_state_out, e);
      end
    end
  endtask

  task automatic test_known(input logic [127:0] k, input logic [127:0] ct,
                            input logic [127:0] pt, input string name);
    int cyc;
    out_ready = 1'b1;
    accept(k, ct, pt);
    wait_out(1, cyc);
    check_result(cyc, name);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_overlap: in_ready=%0b with out_valid, required 0", name, in_ready);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dec_state_out !== pt) begin
      miscompares++;
      $display("FAIL %s_after: vld=%0b rdy=%0b out=%h required 0/1/%h",
               name, out_valid, in_ready, dec_state_out, pt);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad;
    out_ready = 1'b0;
    accept(C1_KEY, C1_CT, C1_PT);
    wait_out(1, cyc);
    check_result(cyc, "bp");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid !== 1'b1 || dec_state_out !== C1_PT || in_ready !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL bp_stall: %0d unstable cycles, required 0 (vld=%0b rdy=%0b out=%h)",
               bad, out_valid, in_ready, dec_state_out);
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: vld=%0b rdy=%0b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_input_change();
    int cyc;
    out_ready = 1'b1;
    accept(C1_KEY, C1_CT, C1_PT);
    cyc = 1;
    while (cyc < 5) begin
      step();
      cyc++;
    end
    // Garbage inputs, with in_valid asserted, must not disturb the block in flight.
    dec_state_in = {$urandom, $urandom, $urandom, $urandom};
    dec_key_in   = {$urandom, $urandom, $urandom, $urandom};
    in_valid     = 1'b1;
    wait_out(cyc, cyc);
    in_valid = 1'b0;
    check_result(cyc, "inchg");
    step();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL inchg_after: vld=%0b rdy=%0b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midflight();
    int cyc;
    int seen;
    logic [127:0] dropped;
    out_ready = 1'b1;
    accept(C1_KEY, C1_CT, C1_PT);
    cyc = 1;
    while (cyc < 6) begin
      step();
      cyc++;
    end
    reset = 1'b0;
    dropped = exp_q.pop_back();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || dec_state_out !== 128'h0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: vld=%0b rdy=%0b out=%h required 0/0/0 (dropped %h)",
               out_valid, in_ready, dec_state_out, dropped);
    end
    step();
    step();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL rst_no_output: out_valid high %0d cycles, required 0", seen);
    end
    test_known(C1_KEY, C1_CT, C1_PT, "rerun");
  endtask

  task automatic test_back_to_back();
    int cyc;
    int nsent;
    int nrecv;
    int overlap;
    int acc_cyc [2];
    logic acc;
    logic [127:0] e;
    out_ready    = 1'b1;
    dec_key_in   = C1_KEY;
    dec_state_in = C1_CT;
    in_valid     = 1'b1;
    cyc = 0;
    nsent = 0;
    nrecv = 0;
    overlap = 0;
    acc_cyc = '{0, 0};
    while (cyc < 60 && nrecv < 2) begin
      if (in_ready && out_valid) overlap++;
      if (out_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_scoreboard: unexpected output %h", dec_state_out);
        end else begin
          e = exp_q.pop_front();
          if (dec_state_out !== e) begin
            miscompares++;
            $display("FAIL b2b_data%0d: got %h required %h", nrecv, dec_state_out, e);
          end
        end
        nrecv++;
      end
      acc = in_ready && in_valid;
      if (acc) begin
        exp_q.push_back(nsent == 0 ? C1_PT : B_PT);
        acc_cyc[nsent] = cyc;
        nsent++;
      end
      step();
      cyc++;
      if (acc) begin
        if (nsent == 1) begin
          dec_key_in   = B_KEY;
          dec_state_in = B_CT;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (nrecv != 2 || nsent != 2) begin
      miscompares++;
      $display("FAIL b2b_count: sent %0d recv %0d required 2/2", nsent, nrecv);
    end
    vectors++;
    if (acc_cyc[1] - acc_cyc[0] != 12) begin
      miscompares++;
      $display("FAIL b2b_spacing: accepts %0d cycles apart, required 12", acc_cyc[1] - acc_cyc[0]);
    end
    vectors++;
    if (overlap != 0) begin
      miscompares++;
      $display("FAIL b2b_overlap: in_ready&out_valid in %0d cycles, required 0", overlap);
    end
  endtask

  initial begin
    reset        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    dec_key_in   = '0;
    dec_state_in = '0;
    test_reset();
    test_known(C1_KEY, C1_CT, C1_PT, "c1");
    test_known(B_KEY, B_CT, B_PT, "appb");
    test_backpressure();
    test_input_change();
    test_reset_midflight();
    test_back_to_back();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes128_decrypt_iter.md
# aes128_decrypt_iter

Iterative AES-128 decryption core: the inverse-direction counterpart of the encryption round datapath. It accepts one 128-bit ciphertext block plus the round-10 (final) key and performs one inverse round per clock, 10 rounds in all. Round keys are derived on the fly by running the key schedule backwards. It sits beside the ECB encryption path and uses the same FIPS-197 byte ordering.

## Interface
Parameters: none. Fixed AES-128, Nr = 10.
- clk  in  1  — single clock, rising edge.
- reset  in  1  — asynchronous, active-low. Low clears all state immediately.
- in_valid  in  1  — ciphertext and key are valid.
- in_ready  out  1  — core can accept; reset value 0, goes high in IDLE.
- dec_key_in  in  128  — round-10 key, i.e. the last word group of the forward expansion.
- dec_state_in  in  128  — ciphertext block.
- out_valid  out  1  — plaintext valid; reset value 0.
- out_ready  in  1  — downstream accepts the plaintext.
- dec_state_out  out  128  — plaintext; reset value 0.

## Operation
- Byte order: byte 0 = bits [127:120]. The state is column-major per FIPS-197; column c = bytes 4c..4c+3.
- FSM states: IDLE, ROUND, DONE. Reset state is IDLE.
- **IDLE**
  - in_ready = 1.
  - On in_valid: state_reg ← dec_state_in ^ dec_key_in, key_reg ← dec_key_in, rnd ← 10, go to ROUND.
- **ROUND** (rnd = 10 down to 1)
  - kprev = inverse key expansion of key_reg with Rcon(rnd).
    - Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36.
    - w0' = w0 ^ SubWord(RotWord(w3 ^ w2)) ^ {Rcon,00,00,00}.
    - w1' = w1 ^ w0, w2' = w2 ^ w1, w3' = w3 ^ w2. Uses the forward S-box.
  - t = InvSubBytes(InvShiftRows(state_reg)) ^ kprev.
  - state_reg ← (rnd == 1) ? t : InvMixColumns(t).
  - key_reg ← kprev, rnd ← rnd − 1.
  - When rnd == 1: load dec_state_out ← final t, go to DONE.
- **DONE**
  - out_valid = 1 and dec_state_out stays stable until out_ready is high.
  - Then go to IDLE.
  - in_ready = 0 in DONE, so no overlap of output and input.
- in_ready and out_valid are never high in the same cycle.
- Inputs are sampled only on the accept cycle. Input changes afterwards are ignored.
- dec_state_out holds the last plaintext after the handshake. It changes only at the next completion or on reset.
- Arithmetic: GF(2^8) with polynomial 0x11b. InvMixColumns coefficients are 0e, 0b, 0d, 09. No carries and no width growth; all values are bytes.

## Timing
- Accept in cycle T (in_valid & in_ready): ROUND occupies cycles T+1..T+10, out_valid is high from T+11.
- Latency is 11 cycles from accept to out_valid. Throughput is one block per 12 cycles when out_ready is held high.
- out_ready low in DONE stalls indefinitely with no loss. out_ready high while not in DONE is ignored.
- in_valid during ROUND or DONE is ignored; the source must hold it until in_ready.
- Reset low in any state: the next state is IDLE, and out_valid, dec_state_out, state_reg, key_reg and rnd are cleared asynchronously. The in-flight block is dropped with no partial output.
- Reset released: in_ready goes high on the first cycle after deassertion.
- All outputs are registered or decoded from FSM state only. There is no combinational path from input to output.

## Structure
- Package aes_dec_pkg holds:
  - forward S-box and inverse S-box functions;
  - Rcon lookup by round index;
  - xtime and gmul helpers;
  - FSM state enum;
  - constant NR = 10.
- Sub-module decrypt_round, purely combinational:
  - inputs: state_in, round_key, last_round flag;
  - output: state_out;
  - order: InvShiftRows → InvSubBytes → AddRoundKey → InvMixColumns, with the last step bypassed when last_round is set.
- Inverse key expansion stays in the top level: one function call plus key_reg.

## Test plan
- FIPS-197 C.1: key 13111d7fe3944a17f307a78b4d2b30c5, ct 69c4e0d86a7b0430d8cdb78070b4c55a → pt 00112233445566778899aabbccddeeff with out_valid exactly 11 cycles after accept.
- FIPS-197 App. B: key d014f9a8c9ee2589e13f0cc8b6630ca6, ct 3925841d02dc09fbdc118597196a0b32 → pt 3243f6a8885a308d313198a2e0370734.
- Backpressure: hold out_ready low for 20 cycles after completion → out_valid and data stay stable, in_ready stays 0. Release → IDLE and in_ready = 1 next cycle.
- Input change during ROUND: alter dec_state_in and dec_key_in at T+5 → result still equals the C.1 plaintext.
- Reset at T+6 → out_valid = 0 and dec_state_out = 0 immediately, no output afterwards. Re-run C.1 after reset → correct result.
- Back-to-back: two blocks (C.1 then App. B) with out_ready tied high and in_valid held → both plaintexts correct in order, accepts 12 cycles apart.
